// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
//   Pipelined carry-look-ahead adder/subtractor. Operands are split into 4-bit
//   look-ahead groups and one group is resolved per pipeline stage, with the
//   group carry registered between stages. A single global advance enable gives
//   one result per clock with full backpressure.
//
// Parameters
//   WIDTH      operand width, a multiple of 4 and at least 4 (GROUPS = WIDTH/4)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat present
//   in_ready   block can accept a beat this cycle (= advance enable)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in, used only when sub=0
//   sub        0: a + b + cin   1: a - b (a + ~b + 1)
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (in sub mode: 1 = no borrow)
//   ovf        signed overflow (carry into MSB xor carry out)
// -----------------------------------------------------------------------------
module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int GROUPS = WIDTH / 4;

  typedef struct packed {
    logic [3:0] s;   // group sum
    logic       c3;  // carry into the group MSB
    logic       c4;  // carry out of the group
  } grp_t;

  // Classic 4-bit look-ahead: every carry is a flat sum-of-products of p, g
  // and the group carry-in, so nothing ripples inside the group.
  function automatic grp_t cla4(input logic [3:0] x, input logic [3:0] y,
                                input logic c0);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1, c2, c3, c4;
    grp_t       res;
    p  = x ^ y;
    g  = x & y;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    res.s  = p ^ {c3, c2, c1, c0};
    res.c3 = c3;
    res.c4 = c4;
    return res;
  endfunction

  // Pipeline registers, one entry per stage. The last stage keeps its result
  // in the dedicated output registers below instead of r_sum/r_carry.
  logic             r_valid [GROUPS];
  logic             r_carry [GROUPS];
  logic [WIDTH-1:0] r_sum   [GROUPS];
  logic [WIDTH-1:0] r_a     [GROUPS];
  logic [WIDTH-1:0] r_b     [GROUPS];
  logic [WIDTH-1:0] r_out_sum;
  logic             r_cout;
  logic             r_ovf;

  // Per-stage inputs (from the ports for stage 0, from the previous stage
  // otherwise) and per-stage next values.
  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic             w_src_v   [GROUPS];
  logic             w_src_c   [GROUPS];
  logic [WIDTH-1:0] w_src_a   [GROUPS];
  logic [WIDTH-1:0] w_src_b   [GROUPS];
  logic [WIDTH-1:0] w_src_sum [GROUPS];
  grp_t             w_grp     [GROUPS];
  logic [WIDTH-1:0] w_nxt_sum [GROUPS];

  // One enable moves the whole pipeline; a stalled output stalls every stage.
  assign w_adv     = ~r_valid[GROUPS-1] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[GROUPS-1];
  assign sum       = r_out_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  // Subtraction is a + ~b + 1: invert b and force the carry-in.
  assign w_b_eff = b ^ {WIDTH{sub}};
  assign w_c0    = sub ? 1'b1 : cin;

  always_comb begin
    // NOTE: every combinational output is assigned on every path (stage 0
    // explicitly, the rest in full loops); a missed path would infer a latch.
    w_src_v[0]   = in_valid;
    w_src_c[0]   = w_c0;
    w_src_a[0]   = a;
    w_src_b[0]   = w_b_eff;
    w_src_sum[0] = '0;
    for (int k = 1; k < GROUPS; k++) begin
      w_src_v[k]   = r_valid[k-1];
      w_src_c[k]   = r_carry[k-1];
      w_src_a[k]   = r_a[k-1];
      w_src_b[k]   = r_b[k-1];
      w_src_sum[k] = r_sum[k-1];
    end
    for (int k = 0; k < GROUPS; k++) begin
      w_grp[k]                = cla4(w_src_a[k][4*k +: 4], w_src_b[k][4*k +: 4],
                                     w_src_c[k]);
      w_nxt_sum[k]            = w_src_sum[k];
      w_nxt_sum[k][4*k +: 4]  = w_grp[k].s;
    end
  end

  // Control and output registers: these carry reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      for (int k = 0; k < GROUPS; k++) r_valid[k] <= 1'b0;
      r_out_sum <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < GROUPS; k++) r_valid[k] <= w_src_v[k];
      // Outputs only change when a real beat lands, so they stay stable
      // across bubbles.
      if (w_src_v[GROUPS-1]) begin
        r_out_sum <= w_nxt_sum[GROUPS-1];
        r_cout    <= w_grp[GROUPS-1].c4;
        r_ovf     <= w_grp[GROUPS-1].c3 ^ w_grp[GROUPS-1].c4;
      end
    end
  end

  // Intermediate datapath registers.
  // NOTE: no reset here on purpose; their contents are qualified by r_valid,
  // so resetting them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int k = 0; k < GROUPS; k++) begin
        r_carry[k] <= w_grp[k].c4;
        r_sum[k]   <= w_nxt_sum[k];
        r_a[k]     <= w_src_a[k];
        r_b[k]     <= w_src_b[k];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
//   Directed bench for cla_pipe_adder at WIDTH=16 (four stages): reset state,
//   hand-computed add/sub vectors with exact latency, a back-to-back stream,
//   backpressure with a full pipeline, and reset while beats are in flight.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

  localparam int W = 16;
  localparam int G = W / 4;
  localparam int NSTREAM = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    logic [15:0] be;
    logic [16:0] r;
    logic        o;
    be = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, be} + 17'(s ? 1'b1 : ci);
    o  = (x[15] == be[15]) && (r[15] != x[15]);
    return {o, r};
  endfunction

  // One isolated beat: not visible after 3 edges, visible after exactly 4,
  // gone one cycle later.
  task automatic send_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic s, input logic [15:0] es,
                          input logic ec, input logic eo);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (G - 2) tick();
    check({tag, " early"}, out_valid, 0);
    tick();
    check({tag, " valid"}, out_valid, 1);
    check({tag, " sum"},   sum,  es);
    check({tag, " cout"},  cout, ec);
    check({tag, " ovf"},   ovf,  eo);
    tick();
    check({tag, " drained"}, out_valid, 0);
  endtask

  logic [15:0] sa [NSTREAM];
  logic [15:0] sb [NSTREAM];
  logic        sc [NSTREAM];
  logic        ss [NSTREAM];
  logic [17:0] se [NSTREAM];
  logic [15:0] bp_a [6];
  logic [15:0] bp_b [6];
  logic        bp_s [6];
  logic [17:0] bp_e [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nxt;
    int  got;
    logic rdy;
    logic acc;
    logic seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst out_valid", out_valid, 0);
    check("rst in_ready",  in_ready,  1);
    check("rst sum",       sum,  0);
    check("rst cout",      cout, 0);
    check("rst ovf",       ovf,  0);

    // Directed vectors, expected values computed by hand
    send_one("ffff+1",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one("7fff+1",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_one("5-7",        16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_one("8000-1",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_one("cin add",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    send_one("cin chain",  16'h0FFF, 16'hF000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one("mid carry",  16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    send_one("equal sub",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    send_one("neg+neg",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Back-to-back stream, out_ready held high
    for (int i = 0; i < NSTREAM; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
      sc[i] = 1'($urandom);
      ss[i] = 1'($urandom);
      se[i] = model(sa[i], sb[i], sc[i], ss[i]);
    end
    for (int i = 0; i < NSTREAM + G; i++) begin
      check($sformatf("stream%0d in_ready", i), in_ready, 1);
      if (i >= G) begin
        check($sformatf("stream%0d valid", i - G), out_valid, 1);
        check($sformatf("stream%0d sum",   i - G), sum,  se[i-G][15:0]);
        check($sformatf("stream%0d cout",  i - G), cout, se[i-G][16]);
        check($sformatf("stream%0d ovf",   i - G), ovf,  se[i-G][17]);
      end
      if (i < NSTREAM) begin
        a = sa[i]; b = sb[i]; cin = sc[i]; sub = ss[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    check("stream drained", out_valid, 0);

    // Backpressure: six beats offered with out_ready low
    for (int j = 0; j < 6; j++) begin
      bp_a[j] = 16'(16'h1111 * (j + 1));
      bp_b[j] = 16'h0F0F;
      bp_s[j] = 1'(j % 2);
      bp_e[j] = model(bp_a[j], bp_b[j], 1'b0, bp_s[j]);
    end
    out_ready = 1'b0;
    cin       = 1'b0;
    nxt       = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      rdy = in_ready;
      if (cyc == G - 1) begin
        check("bp ready before full", in_ready, 1);
        check("bp not yet valid",     out_valid, 0);
      end
      if (cyc == G) begin
        check("bp valid at full",     out_valid, 1);
        check("bp ready drops",       in_ready,  0);
      end
      if (cyc >= G) check($sformatf("bp frozen sum c%0d", cyc), sum, bp_e[0][15:0]);
      in_valid = 1'b1;
      if (rdy) begin
        a = bp_a[nxt]; b = bp_b[nxt]; sub = bp_s[nxt];
      end else begin
        // Wiggle the unaccepted operands; only the accepting edge matters.
        a = ~bp_a[nxt]; b = 16'hDEAD; sub = ~bp_s[nxt];
      end
      tick();
      if (rdy) nxt++;
    end
    check("bp accepted count", nxt, 4);

    // Release: drain in order while the last two beats go in
    a = bp_a[nxt]; b = bp_b[nxt]; sub = bp_s[nxt];
    out_ready = 1'b1;
    #1;
    check("bp release ready", in_ready, 1);
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
      if (out_valid) begin
        check($sformatf("bp out%0d sum",  got), sum,  bp_e[got][15:0]);
        check($sformatf("bp out%0d cout", got), cout, bp_e[got][16]);
        check($sformatf("bp out%0d ovf",  got), ovf,  bp_e[got][17]);
        got++;
      end
      if (nxt < 6) begin
        a = bp_a[nxt]; b = bp_b[nxt]; sub = bp_s[nxt]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid;
      tick();
      if (acc) nxt++;
    end
    check("bp results count", got, 6);
    check("bp all accepted",  nxt, 6);
    check("bp no duplicate",  out_valid, 0);

    // Reset with three beats in flight and a fourth offered on the reset edge
    for (int j = 0; j < 3; j++) begin
      a = bp_a[j]; b = bp_b[j]; sub = bp_s[j]; in_valid = 1'b1;
      tick();
    end
    a = bp_a[3]; b = bp_b[3]; sub = bp_s[3]; in_valid = 1'b1;
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid-rst out_valid", out_valid, 0);
    check("mid-rst sum",       sum,  0);
    check("mid-rst cout",      cout, 0);
    check("mid-rst ovf",       ovf,  0);
    check("mid-rst in_ready",  in_ready, 1);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 2 * G; cyc++) begin
      seen = seen | out_valid;
      tick();
    end
    check("mid-rst no stale beat", seen, 0);
    send_one("post-rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
